// File: rtl/up5bit_counter_ctrl.sv
// rtl/up5bit_counter_ctrl.sv - two-requester round-robin controller driving a shared up-counter
// Optional abort input/aborted output enabled by defining COUNTER_CTRL_ABORT_EN.
module up5bit_counter_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_start,
  input  logic [WIDTH-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_start,
  input  logic [WIDTH-1:0] req1_len,
  output logic             req1_ready,
  input  logic             hold,
`ifdef COUNTER_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             owner,
  output logic             done0,
  output logic             done1
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] out_q, rem_q, start_q, len_q;
  logic             owner_q, busy_q, done0_q, done1_q, rr_q;
  logic [WIDTH-1:0] out_d, rem_d;
  logic             grant0, grant1, abort_w, enter_done_d;

`ifdef COUNTER_CTRL_ABORT_EN
  logic aborted_q;
  assign abort_w = abort;
  assign aborted = aborted_q;
`else
  assign abort_w = 1'b0;
`endif

  // rr_q=0 favours req0; a lone valid always wins regardless of the pointer
  assign grant0     = req0_valid & (~req1_valid | ~rr_q);
  assign grant1     = req1_valid & (~req0_valid | rr_q);
  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;

  assign out_d = out_q + WIDTH'(1);
  assign rem_d = rem_q - WIDTH'(1);

  always_comb begin
    enter_done_d = 1'b0;
    case (state_q)
      LOAD:    enter_done_d = abort_w | (len_q == '0);
      RUN:     enter_done_d = abort_w | (~hold & (rem_q == WIDTH'(1)));
      default: enter_done_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      state_q   <= IDLE;
      out_q     <= '0;
      rem_q     <= '0;
      start_q   <= '0;
      len_q     <= '0;
      owner_q   <= 1'b0;
      busy_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rr_q      <= 1'b0;
`ifdef COUNTER_CTRL_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
`ifdef COUNTER_CTRL_ABORT_EN
      aborted_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            start_q <= req1_ready ? req1_start : req0_start;
            len_q   <= req1_ready ? req1_len : req0_len;
            owner_q <= req1_ready;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (!abort_w) begin
            out_q   <= start_q;
            rem_q   <= len_q;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!abort_w && !hold) begin
            out_q <= out_d;
            rem_q <= rem_d;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          rr_q    <= ~owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Overrides the LOAD/RUN next state chosen above
      if (enter_done_d) begin
        state_q <= DONE;
        done0_q <= ~owner_q;
        done1_q <= owner_q;
`ifdef COUNTER_CTRL_ABORT_EN
        aborted_q <= abort_w;
`endif
      end
    end
  end

  assign out   = out_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign done0 = done0_q;
  assign done1 = done1_q;

endmodule

// File: tb/tb_up5bit_counter_ctrl.sv
// tb/tb_up5bit_counter_ctrl.sv - directed self-checking bench for up5bit_counter_ctrl
module tb_up5bit_counter_ctrl;

  logic       clock0 = 1'b0;
  logic       reset, hold;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0] req0_start, req0_len, req1_start, req1_len, out;
  logic       busy, owner, done0, done1;
`ifdef COUNTER_CTRL_ABORT_EN
  logic       abort, aborted;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock0 = ~clock0;

  up5bit_counter_ctrl #(.WIDTH(5)) dut (
    .clock0(clock0), .reset(reset),
    .req0_valid(req0_valid), .req0_start(req0_start), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_start(req1_start), .req1_len(req1_len), .req1_ready(req1_ready),
    .hold(hold),
`ifdef COUNTER_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .out(out), .busy(busy), .owner(owner), .done0(done0), .done1(done1)
  );

  task automatic step();
    @(posedge clock0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] wrap_seq [5];
    wrap_seq = '{5'd30, 5'd31, 5'd0, 5'd1, 5'd2};
    reset = 1'b1; hold = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_start = '0; req0_len = '0; req1_start = '0; req1_len = '0;
`ifdef COUNTER_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    step(); step();
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    reset = 1'b0;

    // req0 start=5 len=3
    req0_valid = 1'b1; req0_start = 5'd5; req0_len = 5'd3;
    #1 chk("t1_ready0", req0_ready, 1);
    step();
    req0_valid = 1'b0; req0_start = 5'd17; req0_len = 5'd9;
    chk("t1_busy_e0", busy, 1);
    chk("t1_ready0_off", req0_ready, 0);
    step(); chk("t1_e1", out, 5);
    step(); chk("t1_e2", out, 6);
    step(); chk("t1_e3", out, 7); chk("t1_done_early", done0, 0);
    step(); chk("t1_e4", out, 8); chk("t1_done0", done0, 1); chk("t1_busy_done", busy, 1);
    step(); chk("t1_done0_off", done0, 0); chk("t1_idle", busy, 0); chk("t1_hold_out", out, 8);

    // req1 start=30 len=4 wraps through zero
    req1_valid = 1'b1; req1_start = 5'd30; req1_len = 5'd4;
    #1 chk("t2_ready1", req1_ready, 1);
    step(); req1_valid = 1'b0;
    chk("t2_owner", owner, 1);
    for (int i = 0; i < 5; i++) begin
      step(); chk("t2_seq", out, wrap_seq[i]);
    end
    chk("t2_done1", done1, 1); chk("t2_done0", done0, 0);
    step(); chk("t2_done1_off", done1, 0);

    // simultaneous requests after reset: alternation
    reset = 1'b1; step(); reset = 1'b0;
    req0_valid = 1'b1; req0_start = 5'd0;  req0_len = 5'd1;
    req1_valid = 1'b1; req1_start = 5'd20; req1_len = 5'd1;
    #1 chk("t3_grant_a", {req1_ready, req0_ready}, 2'b01);
    step(); chk("t3_owner_a", owner, 0);
    step(); chk("t3_a_e1", out, 0);
    step(); chk("t3_a_e2", out, 1); chk("t3_done0", done0, 1);
    step(); chk("t3_grant_b", {req1_ready, req0_ready}, 2'b10);
    step(); chk("t3_owner_b", owner, 1);
    step(); chk("t3_b_e1", out, 20);
    step(); chk("t3_b_e2", out, 21); chk("t3_done1", done1, 1);
    step(); chk("t3_grant_c", {req1_ready, req0_ready}, 2'b01);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(); chk("t3_no_accept", busy, 0);

    // len=0
    req0_valid = 1'b1; req0_start = 5'd7; req0_len = 5'd0;
    step(); req0_valid = 1'b0;
    step(); chk("t4_out", out, 7); chk("t4_done0", done0, 1);
    step(); chk("t4_done_off", done0, 0); chk("t4_final", out, 7); chk("t4_busy", busy, 0);

    // hold for 3 cycles mid-run
    req0_valid = 1'b1; req0_start = 5'd0; req0_len = 5'd5;
    step(); req0_valid = 1'b0;
    step(); chk("t5_e1", out, 0);
    step(); chk("t5_e2", out, 1);
    step(); chk("t5_e3", out, 2);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("t5_stall", out, 2); chk("t5_no_done", done0, 0);
    end
    hold = 1'b0;
    step(); chk("t5_r1", out, 3);
    step(); chk("t5_r2", out, 4);
    step(); chk("t5_r3", out, 5); chk("t5_done0", done0, 1);
    step();

    // reset during a req1 run
    req1_valid = 1'b1; req1_start = 5'd10; req1_len = 5'd8;
    step(); req1_valid = 1'b0;
    step(); chk("t6_e1", out, 10);
    step(); step(); chk("t6_e3", out, 12);
    reset = 1'b1;
    step(); chk("t6_rst_out", out, 0); chk("t6_rst_busy", busy, 0); chk("t6_rst_done", done1, 0);
    reset = 1'b0;
    step(); chk("t6_no_done", {done1, done0}, 0);
    req0_valid = 1'b1; req0_start = 5'd3; req0_len = 5'd2;
    step(); req0_valid = 1'b0;
    step(); chk("t6_r_e1", out, 3);
    step(); chk("t6_r_e2", out, 4);
    step(); chk("t6_r_e3", out, 5); chk("t6_r_done0", done0, 1); chk("t6_r_owner", owner, 0);
    step();

`ifdef COUNTER_CTRL_ABORT_EN
    req1_valid = 1'b1; req1_start = 5'd10; req1_len = 5'd8;
    step(); req1_valid = 1'b0;
    step(); step(); step(); step(); chk("t7_pre", out, 13);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk("t7_done1", done1, 1); chk("t7_aborted", aborted, 1); chk("t7_out", out, 13);
    step(); chk("t7_aborted_off", aborted, 0); chk("t7_busy", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/up5bit_counter_ctrl.md
Name: up5bit_counter_ctrl

Overview:
- Sequencing controller and round-robin arbiter that owns one up-counter datapath (default 5 bits) and shares it between two requesters.
- Each requester issues a run command (start value, increment count) through a valid/ready handshake.
- The controller loads the counter, steps it the requested number of times, then pulses a per-requester done.
- Sits between fabric-side command sources and the counter output pads used by the up5bit_counter fabric tests.

Parameters:
WIDTH, 5, counter width; also the width of start and length fields.

Ports:
clock0  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 command valid
req0_start  input  WIDTH  requester 0 counter start value
req0_len  input  WIDTH  requester 0 number of increments (0..2^WIDTH-1)
req0_ready  output  1  requester 0 command accepted this cycle
req1_valid  input  1  requester 1 command valid
req1_start  input  WIDTH  requester 1 counter start value
req1_len  input  WIDTH  requester 1 number of increments
req1_ready  output  1  requester 1 command accepted this cycle
hold  input  1  freezes counting while in RUN
out  output  WIDTH  registered counter value
busy  output  1  high whenever state != IDLE
owner  output  1  requester index of current or most recent run
done0  output  1  one-cycle pulse: requester 0 run complete
done1  output  1  one-cycle pulse: requester 1 run complete

Behaviour:
- Clock and reset: one clock, clock0; reset is synchronous and active-high.
- Reset values: state=IDLE, out=0, busy=0, owner=0, done0=done1=0, rr pointer favours req0. Reset mid-run aborts the run with no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - grant = round-robin winner among asserted valids.
  - reqN_ready = (state==IDLE) & grantN, combinational; at most one ready is high.
  - Handshake occurs when valid & ready. On that edge: latch start/len, set owner=N, go to LOAD.
  - A valid dropped before ready has no effect.
  - No valid: stay in IDLE; out holds.
- LOAD (1 cycle): out<=start, remaining<=len. Next state is RUN if len!=0, else DONE.
- RUN:
  - If hold=0: out<=out+1 modulo 2^WIDTH (31+1=0 at WIDTH=5) and remaining<=remaining-1.
  - When an increment occurs with remaining==1, go to DONE.
  - If hold=1: out and remaining are frozen; hold is ignored in every other state.
- DONE (1 cycle): done[owner]=1; rr pointer gives priority to the other requester; go to IDLE. out holds its final value.
- Timing, with the accept edge as E0:
  - out=start visible after E1.
  - After E(1+len) with no hold, out = start+len (mod 2^WIDTH) and done is visible.
  - Earliest next accept is the IDLE cycle after DONE, i.e. minimum command-to-command spacing is len+3 cycles.
- Arbitration:
  - Both valid in IDLE: the pointer side wins.
  - Only one valid: that requester wins regardless of the pointer.
- Valid held high across DONE re-enters arbitration normally; there is no back-to-back grant bypass.
- Inputs start/len are sampled only on the accept edge; later changes are ignored.

Optional Feature:
Macro: COUNTER_CTRL_ABORT_EN
- With the macro defined:
  - Adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in LOAD or RUN goes to DONE next edge. out keeps its current value; the LOAD value is not applied if aborted in LOAD.
  - done[owner] pulses with aborted=1 in the same cycle; aborted=0 otherwise and on reset.
  - abort in IDLE/DONE is ignored.
  - abort has priority over hold and over normal completion.
- Without the macro: both ports are absent; behaviour is as above.

Test Plan:
- Reset, then req0 start=5 len=3, no hold: req0_ready pulses at accept. out=5 at E1, 6, 7, 8 at E2..E4. done0 is high exactly one cycle after E4; busy=1 from E0 through DONE.
- req1 start=30 len=4: out sequence 30, 31, 0, 1, 2 (wrap check); done1 pulses once; owner=1.
- req0 and req1 valid together after reset: req0 granted first. req1 is granted in the IDLE cycle after done0. A further simultaneous request then grants req0 (alternation).
- req0 start=7 len=0: out=7 after E1, DONE follows immediately, done0 pulses, no increment.
- req0 start=0 len=5 with hold=1 for 3 cycles mid-RUN: out stalls 3 cycles. Final out=5 and done0 arrive 3 cycles later than the no-hold case.
- Reset asserted during RUN of req1 start=10 len=8: next edge out=0, busy=0, no done1. A later req0 command runs normally. With COUNTER_CTRL_ABORT_EN: abort at out=13 gives done1 + aborted=1 with out=13.
